// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch/sequencer stage. Holds a loadable program
//            memory and a program counter and walks the program. JMP and
//            HALT are resolved locally; every other word is handed to the
//            controller as a {func, val} pair over a valid/ready handshake.
// Ports    : clk, reset (async, active-high)
//            start               - level, begins execution at address 0
//                                  from IDLE or HALT
//            load_en/addr/func/val - program-memory write port, honoured
//                                  only in IDLE or HALT
//            instr_ready         - controller accepts the current word
//            instr_valid         - funcsaidaMemory/valMemory hold a word
//            funcsaidaMemory     - issued func field
//            valMemory           - issued val field
//            pc_out              - current program counter
//            halted              - HALT_OP reached
//            busy                - state is READ, DECODE or ISSUE
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 4,
  parameter int VAL_W  = 4,
  parameter logic [FUNC_W-1:0] JMP_OP  = FUNC_W'(4'hE),
  parameter logic [FUNC_W-1:0] HALT_OP = FUNC_W'(4'hF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [FUNC_W-1:0] load_func,
  input  logic [VAL_W-1:0]  load_val,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [FUNC_W-1:0] funcsaidaMemory,
  output logic [VAL_W-1:0]  valMemory,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              busy
);

  localparam int WORD_W = FUNC_W + VAL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [FUNC_W-1:0]   func_q, func_d;
  logic [VAL_W-1:0]    val_q, val_d;
  logic                halted_q, halted_d;
  logic [WORD_W-1:0]   rd_word_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [FUNC_W-1:0]   dec_func;
  logic [VAL_W-1:0]    dec_val;
  logic [ADDR_W-1:0]   jmp_target;

  // The program may only be rewritten while the sequencer is parked, so a
  // running program never sees its own words change underneath it.
  assign mem_we = load_en && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  // Program memory is deliberately outside the reset domain: a reset must
  // restart the program, not erase it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= {load_func, load_val};
    end
  end

  // Synchronous read, launched in READ and consumed in DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_word_q <= '0;
    end else if (state_q == ST_READ) begin
      rd_word_q <= mem_q[pc_q];
    end
  end

  assign dec_func = rd_word_q[WORD_W-1:VAL_W];
  assign dec_val  = rd_word_q[VAL_W-1:0];

  // Jump target: the val field is zero-extended or truncated to the PC width.
  generate
    if (VAL_W >= ADDR_W) begin : g_jmp_trunc
      assign jmp_target = dec_val[ADDR_W-1:0];
    end else begin : g_jmp_ext
      assign jmp_target = {{(ADDR_W - VAL_W){1'b0}}, dec_val};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      func_q   <= '0;
      val_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      func_q   <= func_d;
      val_q    <= val_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    func_d   = func_q;
    val_d    = val_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous load wins over start so the write is not lost.
        if (start && !load_en) begin
          pc_d    = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_func == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (dec_func == JMP_OP) begin
          pc_d    = jmp_target;
          state_d = ST_READ;
        end else begin
          func_d  = dec_func;
          val_d   = dec_val;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Data registers keep their value after the transfer; only valid drops.
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr_valid     = valid_q;
  assign funcsaidaMemory = func_q;
  assign valMemory       = val_q;
  assign pc_out          = pc_q;
  assign halted          = halted_q;
  assign busy            = (state_q == ST_READ) || (state_q == ST_DECODE) ||
                           (state_q == ST_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A program-level interpreter
//            predicts the sequence of issued words, the cycles between them,
//            the PC after each transfer and the final halt address.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [3:0] load_func = '0;
  logic [3:0] load_val = '0;
  logic       instr_ready = 1'b0;
  logic       instr_valid;
  logic [3:0] funcsaidaMemory;
  logic [3:0] valMemory;
  logic [3:0] pc_out;
  logic       halted;
  logic       busy;

  instr_fetch #(
    .ADDR_W (4),
    .FUNC_W (4),
    .VAL_W  (4),
    .JMP_OP (4'hE),
    .HALT_OP(4'hF)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_func      (load_func),
    .load_val       (load_val),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .funcsaidaMemory(funcsaidaMemory),
    .valMemory      (valMemory),
    .pc_out         (pc_out),
    .halted         (halted),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference program image and predicted behaviour.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_w   [$];
  logic [3:0] exp_pc  [$];
  int         exp_gap [$];
  bit         exp_halt;
  bit         exp_stuck;
  logic [3:0] exp_halt_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Interpret the program from address 0: HALT stops, JMP redirects (costing
  // two extra cycles), anything else is issued and advances the PC mod 16.
  function automatic void build_model(input int max_xfers);
    int         pc;
    int         jumps;
    logic [7:0] w;
    pc = 0;
    jumps = 0;
    exp_w.delete();
    exp_pc.delete();
    exp_gap.delete();
    exp_halt = 0;
    exp_stuck = 0;
    exp_halt_pc = '0;
    while (1) begin
      w = ref_mem[pc];
      if (w[7:4] == 4'hF) begin
        exp_halt = 1;
        exp_halt_pc = 4'(pc);
        break;
      end else if (w[7:4] == 4'hE) begin
        pc = int'(w[3:0]);
        jumps++;
        if (jumps > 64) begin
          exp_stuck = 1;
          break;
        end
      end else begin
        exp_w.push_back(w);
        pc = (pc + 1) % 16;
        exp_pc.push_back(4'(pc));
        exp_gap.push_back(3 + 2 * jumps);
        jumps = 0;
        if (exp_w.size() >= max_xfers) break;
      end
    end
  endfunction

  task automatic load_word(input logic [3:0] a, input logic [3:0] f, input logic [3:0] v);
    load_en = 1'b1;
    load_addr = a;
    load_func = f;
    load_val = v;
    tick;
    load_en = 1'b0;
    ref_mem[a] = {f, v};
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    check("rst_valid",  32'(instr_valid), 32'(0));
    check("rst_func",   32'(funcsaidaMemory), 32'(0));
    check("rst_val",    32'(valMemory), 32'(0));
    check("rst_pc",     32'(pc_out), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_busy",   32'(busy), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick;
  endtask

  // mode 0: ready always high (issue spacing checked)
  // mode 1: random ready
  // mode 2: ready held low for 5 cycles of the first valid word, optionally
  //         with a load pulse to address 1 while the word is pending
  task automatic run_prog(input int mode, input int max_xfers, input bit do_load);
    int         last;
    int         budget;
    int         hold_left;
    int         nvalid;
    int         g;
    bit         held_v;
    bit         rdy;
    bit         pend;
    bit         done;
    logic [7:0] held_w;
    logic [7:0] w;
    logic [3:0] pcx;
    build_model(max_xfers);
    held_v = 0;
    held_w = '0;
    hold_left = 5;
    pend = 0;
    done = 0;
    pcx = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    last = cyc;
    budget = 0;
    while (!done && budget < 3000) begin
      if (held_v) begin
        check("hold_valid", 32'(instr_valid), 32'(1));
        check("hold_data", 32'({funcsaidaMemory, valMemory}), 32'(held_w));
      end
      load_en = 1'b0;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (instr_valid && hold_left > 0) begin
            if (do_load && hold_left == 5) begin
              load_en = 1'b1;
              load_addr = 4'd1;
              load_func = 4'd7;
              load_val = 4'd7;
            end
            rdy = 1'b0;
            hold_left--;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      instr_ready = rdy;
      held_v = instr_valid && !rdy;
      held_w = {funcsaidaMemory, valMemory};
      if (instr_valid && rdy) begin
        if (exp_w.size() == 0) begin
          check("extra_xfer", 32'(1), 32'(0));
        end else begin
          w = exp_w.pop_front();
          g = exp_gap.pop_front();
          pcx = exp_pc.pop_front();
          check("xfer_data", 32'({funcsaidaMemory, valMemory}), 32'(w));
          if (mode == 0) check("xfer_gap", 32'(cyc + 1 - last), 32'(g));
          last = cyc + 1;
          pend = 1;
        end
      end
      tick;
      budget++;
      if (pend) begin
        check("pc_after", 32'(pc_out), 32'(pcx));
        check("valid_drop", 32'(instr_valid), 32'(0));
        pend = 0;
      end
      if (exp_w.size() == 0) begin
        if (exp_halt) done = halted;
        else done = 1;
      end
    end
    if (!done) check("timeout", 32'(0), 32'(1));
    if (exp_halt) begin
      check("halt_flag",  32'(halted), 32'(1));
      check("halt_pc",    32'(pc_out), 32'(exp_halt_pc));
      check("halt_busy",  32'(busy), 32'(0));
      check("halt_valid", 32'(instr_valid), 32'(0));
    end
    if (exp_stuck) begin
      nvalid = 0;
      instr_ready = 1'b1;
      repeat (40) begin
        tick;
        if (instr_valid) nvalid++;
      end
      check("stuck_no_issue", 32'(nvalid), 32'(0));
      check("stuck_busy", 32'(busy), 32'(1));
    end
    instr_ready = 1'b0;
    load_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick;
    do_reset();

    // Basic program: two issues then halt at address 2.
    load_word(4'd0, 4'd1, 4'd3);
    load_word(4'd1, 4'd2, 4'd5);
    load_word(4'd2, 4'hF, 4'd0);
    run_prog(0, 8, 0);

    // Back-pressure from HALT restart, then a load attempt while issuing.
    run_prog(2, 8, 0);
    run_prog(2, 8, 1);

    // Reset in the middle of an issue; memory must survive.
    start = 1'b1;
    tick;
    start = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && !instr_valid; i++) tick;
    check("issue_seen", 32'(instr_valid), 32'(1));
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(instr_valid), 32'(0));
    check("mid_rst_pc",    32'(pc_out), 32'(0));
    check("mid_rst_func",  32'(funcsaidaMemory), 32'(0));
    check("mid_rst_val",   32'(valMemory), 32'(0));
    check("mid_rst_busy",  32'(busy), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick;
    run_prog(0, 8, 0);

    // Jump over addresses 1..3.
    do_reset();
    load_word(4'd0, 4'hE, 4'd4);
    load_word(4'd4, 4'd3, 4'd9);
    load_word(4'd5, 4'hF, 4'd0);
    run_prog(0, 8, 0);

    // Straight-line program covering the full address space and the wrap.
    do_reset();
    for (int a = 0; a < 16; a++) load_word(4'(a), 4'd1, 4'(a));
    run_prog(0, 17, 0);

    // Random programs with random back-pressure.
    for (int t = 0; t < 10; t++) begin
      logic [3:0] f;
      logic [3:0] v;
      int         r;
      do_reset();
      for (int a = 0; a < 16; a++) begin
        r = int'($urandom_range(0, 9));
        v = 4'($urandom_range(0, 15));
        if (r == 0) f = 4'hF;
        else if (r == 1) f = 4'hE;
        else f = 4'($urandom_range(0, 13));
        load_word(4'(a), f, v);
      end
      run_prog(int'($urandom_range(0, 1)), 20, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
